// File: rtl/ga_pkg.sv
// Shared state encoding and default widths for the GA fitness scheduler.
package ga_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ga_state_e;

    localparam int DEF_INDIVIDUAL_WIDTH = 64;
    localparam int DEF_ERROR_WIDTH      = 5;
    localparam int DEF_LANES            = 4;
    localparam int DEF_POP_ADDR_WIDTH   = 5;
    localparam int DEF_GENERATION_WIDTH = 16;

endpackage

// File: rtl/morphologic_ga_lane.sv
// One fitness lane slot: holds the operand in flight and its result
// until the scheduler drains it.
module morphologic_ga_lane
    import ga_pkg::*;
#(
    parameter int IndividualWidth = DEF_INDIVIDUAL_WIDTH,
    parameter int ErrorWidth      = DEF_ERROR_WIDTH,
    parameter int AddrWidth       = DEF_POP_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       accept,
    input  logic [AddrWidth-1:0]       accept_index,
    input  logic [IndividualWidth-1:0] accept_individual,
    input  logic                       finish,
    input  logic [ErrorWidth-1:0]      finish_error,
    input  logic                       emit,
    output logic                       busy,
    output logic                       pending,
    output logic [AddrWidth-1:0]       index,
    output logic [ErrorWidth-1:0]      error,
    output logic                       start,
    output logic [IndividualWidth-1:0] individual
);

    logic                       busy_q, busy_d;
    logic                       pending_q, pending_d;
    logic                       start_q, start_d;
    logic [AddrWidth-1:0]       index_q, index_d;
    logic [ErrorWidth-1:0]      error_q, error_d;
    logic [IndividualWidth-1:0] individual_q, individual_d;

    always_comb begin
        busy_d       = busy_q;
        pending_d    = pending_q;
        start_d      = 1'b0;
        index_d      = index_q;
        error_d      = error_q;
        individual_d = individual_q;
        if (clr) begin
            busy_d       = 1'b0;
            pending_d    = 1'b0;
            index_d      = '0;
            error_d      = '0;
            individual_d = '0;
        end else begin
            if (accept) begin
                busy_d       = 1'b1;
                start_d      = 1'b1;
                index_d      = accept_index;
                individual_d = accept_individual;
            end
            // A second finish while a result waits is dropped.
            if (finish && busy_q && !pending_q) begin
                pending_d = 1'b1;
                error_d   = finish_error;
            end
            if (emit) begin
                busy_d    = 1'b0;
                pending_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q       <= 1'b0;
            pending_q    <= 1'b0;
            start_q      <= 1'b0;
            index_q      <= '0;
            error_q      <= '0;
            individual_q <= '0;
        end else begin
            busy_q       <= busy_d;
            pending_q    <= pending_d;
            start_q      <= start_d;
            index_q      <= index_d;
            error_q      <= error_d;
            individual_q <= individual_d;
        end
    end

    assign busy       = busy_q;
    assign pending    = pending_q;
    assign index      = index_q;
    assign error      = error_q;
    assign start      = start_q;
    assign individual = individual_q;

endmodule

// File: rtl/morphologic_ga_scheduler.sv
// Dispatches GA individuals to parallel fitness lanes, drains results
// in lane order and tracks the best individual per run.
module morphologic_ga_scheduler
    import ga_pkg::*;
#(
    parameter int IndividualWidth        = DEF_INDIVIDUAL_WIDTH,
    parameter int ErrorWidth             = DEF_ERROR_WIDTH,
    parameter int Lanes                  = DEF_LANES,
    parameter int PopulationAddressWidth = DEF_POP_ADDR_WIDTH,
    parameter int GenerationWidth        = DEF_GENERATION_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [ErrorWidth-1:0]               threshold,
    input  logic [GenerationWidth-1:0]          maxGenerations,
    input  logic                                reqValid,
    input  logic [IndividualWidth-1:0]          reqIndividual,
    input  logic [PopulationAddressWidth-1:0]   reqIndex,
    output logic                                reqReady,
    output logic [Lanes-1:0]                    laneStart,
    output logic [Lanes*IndividualWidth-1:0]    laneIndividual,
    input  logic [Lanes-1:0]                    laneFinish,
    input  logic [Lanes*ErrorWidth-1:0]         laneError,
    output logic                                resultValid,
    output logic [PopulationAddressWidth-1:0]   resultIndex,
    output logic [ErrorWidth-1:0]               resultError,
    output logic [IndividualWidth-1:0]          bestIndividual,
    output logic [ErrorWidth-1:0]               bestError,
    output logic [GenerationWidth-1:0]          generation,
    output logic                                busy,
    output logic                                done,
    output logic                                cycle
);

    localparam int IW = IndividualWidth;
    localparam int AW = PopulationAddressWidth;

    ga_state_e state_q, state_d;

    logic [Lanes-1:0] lane_busy;
    logic [Lanes-1:0] lane_pending;
    logic [Lanes-1:0] free_vec;
    logic [Lanes-1:0] accept_vec;
    logic [Lanes-1:0] grant_vec;
    logic [AW-1:0]    lane_index [Lanes];
    logic [ErrorWidth-1:0] lane_error [Lanes];

    logic start_run;
    logic stop;
    logic emit;
    logic wrap;
    logic [IW-1:0] result_individual;

    logic [GenerationWidth-1:0] generation_q, generation_d;
    logic [ErrorWidth-1:0]      best_error_q, best_error_d;
    logic [IW-1:0]              best_ind_q, best_ind_d;
    logic [AW-1:0]              count_q, count_d;
    logic                       cycle_q, cycle_d;

    for (genvar g = 0; g < Lanes; g++) begin : g_lane
        morphologic_ga_lane #(
            .IndividualWidth (IW),
            .ErrorWidth      (ErrorWidth),
            .AddrWidth       (AW)
        ) u_lane (
            .clk               (clk),
            .rst_n             (rst),
            .clr               (start_run),
            .accept            (accept_vec[g]),
            .accept_index      (reqIndex),
            .accept_individual (reqIndividual),
            .finish            (laneFinish[g]),
            .finish_error      (laneError[g*ErrorWidth +: ErrorWidth]),
            .emit              (grant_vec[g]),
            .busy              (lane_busy[g]),
            .pending           (lane_pending[g]),
            .index             (lane_index[g]),
            .error             (lane_error[g]),
            .start             (laneStart[g]),
            .individual        (laneIndividual[g*IW +: IW])
        );
    end

    // Lowest-index priority for both dispatch and drain.
    always_comb begin
        logic found_free;
        logic found_pend;
        free_vec   = '0;
        grant_vec  = '0;
        found_free = 1'b0;
        found_pend = 1'b0;
        for (int i = 0; i < Lanes; i++) begin
            if (!lane_busy[i] && !found_free) begin
                free_vec[i] = 1'b1;
                found_free  = 1'b1;
            end
            if (lane_pending[i] && !found_pend) begin
                grant_vec[i] = 1'b1;
                found_pend   = 1'b1;
            end
        end
        accept_vec = (reqValid && reqReady) ? free_vec : '0;
    end

    always_comb begin
        resultIndex       = '0;
        resultError       = '0;
        result_individual = '0;
        for (int i = 0; i < Lanes; i++) begin
            if (grant_vec[i]) begin
                resultIndex       = lane_index[i];
                resultError       = lane_error[i];
                result_individual = laneIndividual[i*IW +: IW];
            end
        end
        resultValid = |grant_vec;
    end

    assign stop = (best_error_q <= threshold)
               || (generation_q == maxGenerations);
    assign emit = |grant_vec;
    assign wrap = emit && (count_q == '1);

    always_comb begin
        generation_d = generation_q;
        best_error_d = best_error_q;
        best_ind_d   = best_ind_q;
        count_d      = count_q;
        cycle_d      = 1'b0;
        if (start_run) begin
            generation_d = '0;
            best_error_d = '1;
            best_ind_d   = '0;
            count_d      = '0;
        end else begin
            // Strict less-than keeps the earlier of two equal results.
            if (emit) begin
                count_d = count_q + 1'b1;
                if (resultError < best_error_q) begin
                    best_error_d = resultError;
                    best_ind_d   = result_individual;
                end
            end
            if (wrap) begin
                cycle_d = 1'b1;
                if (generation_q != '1) begin
                    generation_d = generation_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            generation_q <= '0;
            best_error_q <= '1;
            best_ind_q   <= '0;
            count_q      <= '0;
            cycle_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            generation_q <= generation_d;
            best_error_q <= best_error_d;
            best_ind_q   <= best_ind_d;
            count_q      <= count_d;
            cycle_q      <= cycle_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (stop) state_d = ST_DRAIN;
            ST_DRAIN: if (!(|lane_busy)) state_d = ST_DONE;
            ST_DONE:  if (start) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        start_run = start
                 && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        reqReady  = (state_q == ST_RUN) && !stop && !(&lane_busy);
        busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        done      = (state_q == ST_DONE);
    end

    assign generation     = generation_q;
    assign bestError      = best_error_q;
    assign bestIndividual = best_ind_q;
    assign cycle          = cycle_q;

endmodule

// File: tb/tb_morphologic_ga_scheduler.sv
// Directed bench for the GA scheduler: a per-cycle vector table plus
// hand-written multi-cycle sequences.
module tb_morphologic_ga_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  threshold;
    logic [7:0]  max_gen;
    logic        req_valid;
    logic [15:0] req_ind;
    logic [1:0]  req_idx;
    logic        req_ready;
    logic [3:0]  lane_start;
    logic [63:0] lane_ind;
    logic [3:0]  lane_fin;
    logic [19:0] lane_err;
    logic        result_valid;
    logic [1:0]  result_index;
    logic [4:0]  result_error;
    logic [15:0] best_ind;
    logic [4:0]  best_err;
    logic [7:0]  generation;
    logic        busy;
    logic        done;
    logic        cyc;

    int n_checks = 0;
    int n_pass   = 0;
    int n_res    = 0;
    int n_cyc    = 0;

    morphologic_ga_scheduler #(
        .IndividualWidth        (16),
        .ErrorWidth             (5),
        .Lanes                  (4),
        .PopulationAddressWidth (2),
        .GenerationWidth        (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .threshold      (threshold),
        .maxGenerations (max_gen),
        .reqValid       (req_valid),
        .reqIndividual  (req_ind),
        .reqIndex       (req_idx),
        .reqReady       (req_ready),
        .laneStart      (lane_start),
        .laneIndividual (lane_ind),
        .laneFinish     (lane_fin),
        .laneError      (lane_err),
        .resultValid    (result_valid),
        .resultIndex    (result_index),
        .resultError    (result_error),
        .bestIndividual (best_ind),
        .bestError      (best_err),
        .generation     (generation),
        .busy           (busy),
        .done           (done),
        .cycle          (cyc)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (result_valid) n_res++;
        if (cyc) n_cyc++;
    end

    typedef struct {
        logic        start;
        logic        valid;
        logic [1:0]  idx;
        logic [15:0] ind;
        logic [3:0]  fin;
        logic [19:0] err;
        logic        e_ready;
        logic [3:0]  e_lstart;
        logic        e_rvalid;
        logic [1:0]  e_ridx;
        logic [4:0]  e_rerr;
        logic [4:0]  e_best;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    localparam int NV = 14;
    vec_t v [NV];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic clear_inputs();
        start     = 1'b0;
        req_valid = 1'b0;
        req_ind   = 16'h0;
        req_idx   = 2'd0;
        lane_fin  = 4'h0;
        lane_err  = 20'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic next_cyc();
        @(negedge clk);
    endtask

    task automatic offer(input logic [1:0] idx, input logic [15:0] ind);
        @(negedge clk);
        req_valid = 1'b1;
        req_idx   = idx;
        req_ind   = ind;
    endtask

    task automatic wait_done(input string nm, input int max_cyc);
        int k;
        k = 0;
        while (!done && k < max_cyc) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk(nm, 32'(done), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r0;
        int c0;

        // lane1 err 7, lane3 err 2
        v[0]  = '{1'b1, 1'b0, 2'd0, 16'h0000, 4'b0000, 20'h00000,
                  1'b0, 4'b0000, 1'b0, 2'd0, 5'd0, 5'd31, 1'b0, 1'b0};
        v[1]  = '{1'b0, 1'b1, 2'd0, 16'hA000, 4'b0000, 20'h00000,
                  1'b1, 4'b0000, 1'b0, 2'd0, 5'd0, 5'd31, 1'b1, 1'b0};
        v[2]  = '{1'b0, 1'b1, 2'd1, 16'hA001, 4'b0000, 20'h00000,
                  1'b1, 4'b0001, 1'b0, 2'd0, 5'd0, 5'd31, 1'b1, 1'b0};
        v[3]  = '{1'b0, 1'b1, 2'd2, 16'hA002, 4'b0000, 20'h00000,
                  1'b1, 4'b0010, 1'b0, 2'd0, 5'd0, 5'd31, 1'b1, 1'b0};
        v[4]  = '{1'b0, 1'b1, 2'd3, 16'hA003, 4'b0000, 20'h00000,
                  1'b1, 4'b0100, 1'b0, 2'd0, 5'd0, 5'd31, 1'b1, 1'b0};
        v[5]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 4'b0000, 20'h00000,
                  1'b0, 4'b1000, 1'b0, 2'd0, 5'd0, 5'd31, 1'b1, 1'b0};
        v[6]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 4'b1010, 20'h100E0,
                  1'b0, 4'b0000, 1'b0, 2'd0, 5'd0, 5'd31, 1'b1, 1'b0};
        v[7]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 4'b0000, 20'h00000,
                  1'b0, 4'b0000, 1'b1, 2'd1, 5'd7, 5'd31, 1'b1, 1'b0};
        v[8]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 4'b0000, 20'h00000,
                  1'b1, 4'b0000, 1'b1, 2'd3, 5'd2, 5'd7, 1'b1, 1'b0};
        v[9]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 4'b0001, 20'h00009,
                  1'b1, 4'b0000, 1'b0, 2'd0, 5'd0, 5'd2, 1'b1, 1'b0};
        v[10] = '{1'b0, 1'b1, 2'd0, 16'hA004, 4'b0000, 20'h00000,
                  1'b1, 4'b0000, 1'b1, 2'd0, 5'd9, 5'd2, 1'b1, 1'b0};
        v[11] = '{1'b0, 1'b1, 2'd1, 16'hA005, 4'b0000, 20'h00000,
                  1'b1, 4'b0010, 1'b0, 2'd0, 5'd0, 5'd2, 1'b1, 1'b0};
        v[12] = '{1'b0, 1'b0, 2'd0, 16'h0000, 4'b1000, 20'h08000,
                  1'b1, 4'b0001, 1'b0, 2'd0, 5'd0, 5'd2, 1'b1, 1'b0};
        v[13] = '{1'b0, 1'b0, 2'd0, 16'h0000, 4'b0000, 20'h00000,
                  1'b1, 4'b0000, 1'b0, 2'd0, 5'd0, 5'd2, 1'b1, 1'b0};

        threshold = 5'd0;
        max_gen   = 8'd5;
        do_reset();
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_gen", 32'(generation), 32'd0);
        chk("rst_best_err", 32'(best_err), 32'd31);
        chk("rst_best_ind", 32'(best_ind), 32'd0);
        chk("rst_lstart", 32'(lane_start), 32'd0);
        chk("rst_rvalid", 32'(result_valid), 32'd0);
        chk("rst_lane_ind", 32'(|lane_ind), 32'd0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            start     = v[i].start;
            req_valid = v[i].valid;
            req_idx   = v[i].idx;
            req_ind   = v[i].ind;
            lane_fin  = v[i].fin;
            lane_err  = v[i].err;
            #1;
            chk($sformatf("v%0d_ready", i),
                32'(req_ready), 32'(v[i].e_ready));
            chk($sformatf("v%0d_lstart", i),
                32'(lane_start), 32'(v[i].e_lstart));
            chk($sformatf("v%0d_rvalid", i),
                32'(result_valid), 32'(v[i].e_rvalid));
            if (v[i].e_rvalid) begin
                chk($sformatf("v%0d_ridx", i),
                    32'(result_index), 32'(v[i].e_ridx));
                chk($sformatf("v%0d_rerr", i),
                    32'(result_error), 32'(v[i].e_rerr));
            end
            chk($sformatf("v%0d_best", i),
                32'(best_err), 32'(v[i].e_best));
            chk($sformatf("v%0d_busy", i),
                32'(busy), 32'(v[i].e_busy));
            chk($sformatf("v%0d_done", i),
                32'(done), 32'(v[i].e_done));
        end
        chk("tbl_best_ind", 32'(best_ind), 32'h0000A003);
        chk("tbl_lane1_ind", 32'(lane_ind[31:16]), 32'h0000A004);
        chk("tbl_lane2_hold", 32'(lane_ind[47:32]), 32'h0000A002);
        chk("tbl_lane0_ind", 32'(lane_ind[15:0]), 32'h0000A005);

        // Threshold hit drains remaining lanes.
        threshold = 5'd3;
        max_gen   = 8'd10;
        do_reset();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        req_valid = 1'b1; req_idx = 2'd0; req_ind = 16'hB000;
        offer(2'd1, 16'hB001);
        offer(2'd2, 16'hB002);
        next_cyc();
        req_valid = 1'b0;
        lane_fin  = 4'b0001;
        lane_err  = 20'd3;
        next_cyc();
        lane_fin = 4'b0000;
        #1;
        chk("thr_rvalid", 32'(result_valid), 32'd1);
        chk("thr_ridx", 32'(result_index), 32'd0);
        chk("thr_rerr", 32'(result_error), 32'd3);
        offer(2'd3, 16'hB003);
        #1;
        chk("thr_ready_stop", 32'(req_ready), 32'd0);
        next_cyc();
        start    = 1'b1;
        lane_fin = 4'b0110;
        lane_err = 20'h03140;
        #1;
        chk("thr_drain_ready", 32'(req_ready), 32'd0);
        chk("thr_drain_busy", 32'(busy), 32'd1);
        chk("thr_drain_lstart", 32'(lane_start), 32'd0);
        next_cyc();
        start     = 1'b0;
        req_valid = 1'b0;
        lane_fin  = 4'b0000;
        #1;
        chk("thr_r1_idx", 32'(result_index), 32'd1);
        chk("thr_r1_err", 32'(result_error), 32'd10);
        chk("thr_r1_busy", 32'(busy), 32'd1);
        next_cyc();
        #1;
        chk("thr_r2_valid", 32'(result_valid), 32'd1);
        chk("thr_r2_idx", 32'(result_index), 32'd2);
        chk("thr_r2_err", 32'(result_error), 32'd12);
        wait_done("thr_done", 6);
        chk("thr_best_err", 32'(best_err), 32'd3);
        chk("thr_best_ind", 32'(best_ind), 32'h0000B000);
        repeat (3) next_cyc();
        #1;
        chk("thr_done_held", 32'(done), 32'd1);
        chk("thr_done_busy", 32'(busy), 32'd0);

        // Generation limit: 8 results, two generation pulses.
        threshold = 5'd0;
        max_gen   = 8'd2;
        do_reset();
        r0 = n_res;
        c0 = n_cyc;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            req_valid = 1'b1;
            req_idx   = 2'(k);
            req_ind   = 16'hC000 + 16'(k);
            #1;
            chk($sformatf("gen_ready%0d", k), 32'(req_ready), 32'd1);
            next_cyc();
            req_valid = 1'b0;
            lane_fin  = 4'b0001;
            lane_err  = {15'd0, 5'(10 + k % 3)};
            next_cyc();
            lane_fin = 4'b0000;
        end
        wait_done("gen_done", 10);
        chk("gen_results", 32'(n_res - r0), 32'd8);
        chk("gen_pulses", 32'(n_cyc - c0), 32'd2);
        chk("gen_value", 32'(generation), 32'd2);
        chk("gen_best", 32'(best_err), 32'd10);

        // maxGenerations of zero admits nothing.
        threshold = 5'd0;
        max_gen   = 8'd0;
        do_reset();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        req_valid = 1'b1;
        #1;
        chk("mg0_busy", 32'(busy), 32'd1);
        chk("mg0_ready", 32'(req_ready), 32'd0);
        next_cyc();
        #1;
        chk("mg0_lstart", 32'(lane_start), 32'd0);
        req_valid = 1'b0;
        wait_done("mg0_done", 6);

        // Asynchronous reset with lanes in flight.
        threshold = 5'd0;
        max_gen   = 8'd10;
        do_reset();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        req_valid = 1'b1; req_idx = 2'd0; req_ind = 16'hD000;
        offer(2'd1, 16'hD001);
        offer(2'd2, 16'hD002);
        offer(2'd3, 16'hD003);
        next_cyc();
        req_valid = 1'b0;
        lane_fin  = 4'b0001;
        lane_err  = 20'd4;
        next_cyc();
        lane_fin = 4'b0000;
        next_cyc();
        #1;
        chk("ar_pre_best", 32'(best_err), 32'd4);
        chk("ar_pre_busy", 32'(busy), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("ar_ready", 32'(req_ready), 32'd0);
        chk("ar_lstart", 32'(lane_start), 32'd0);
        chk("ar_rvalid", 32'(result_valid), 32'd0);
        chk("ar_cycle", 32'(cyc), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_done", 32'(done), 32'd0);
        chk("ar_gen", 32'(generation), 32'd0);
        chk("ar_best_err", 32'(best_err), 32'd31);
        chk("ar_best_ind", 32'(best_ind), 32'd0);
        chk("ar_lane_ind", 32'(|lane_ind), 32'd0);
        next_cyc();
        rst = 1'b1;
        r0 = n_res;
        next_cyc();
        lane_fin = 4'b1110;
        lane_err = 20'hFFFFF;
        next_cyc();
        lane_fin = 4'b0000;
        repeat (4) next_cyc();
        #1;
        chk("ar_late_results", 32'(n_res - r0), 32'd0);
        chk("ar_idle_busy", 32'(busy), 32'd0);

        // Equal errors keep the earlier individual.
        threshold = 5'd0;
        max_gen   = 8'd10;
        do_reset();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        req_valid = 1'b1; req_idx = 2'd0; req_ind = 16'hAAAA;
        offer(2'd1, 16'hBBBB);
        next_cyc();
        req_valid = 1'b0;
        lane_fin  = 4'b0001;
        lane_err  = 20'd5;
        next_cyc();
        lane_fin = 4'b0010;
        lane_err = 20'h000A0;
        #1;
        chk("tie_first_idx", 32'(result_index), 32'd0);
        next_cyc();
        lane_fin = 4'b0000;
        #1;
        chk("tie_second_idx", 32'(result_index), 32'd1);
        chk("tie_second_err", 32'(result_error), 32'd5);
        next_cyc();
        #1;
        chk("tie_best_err", 32'(best_err), 32'd5);
        chk("tie_best_ind", 32'(best_ind), 32'h0000AAAA);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/morphologic_ga_scheduler.md
MORPHOLOGIC_GA_SCHEDULER -- requirements
Module: morphologic_ga_scheduler

Interface
REQ-001 SHALL have parameters: IndividualWidth, default 64, individual bit width; ErrorWidth, default 5, fitness error width; Lanes, default 4, parallel fitness units (1..8); PopulationAddressWidth, default 5, log2 population size; GenerationWidth, default 16, generation counter width.
REQ-002 SHALL have ports: clk in 1 clock; rst in 1 reset, asynchronous, active-low; start in 1 run request pulse; threshold in ErrorWidth stop-error target; maxGenerations in GenerationWidth generation limit.
REQ-003 SHALL have ports: reqValid in 1 individual offered; reqIndividual in IndividualWidth; reqIndex in PopulationAddressWidth; reqReady out 1 individual accepted.
REQ-004 SHALL have ports: laneStart out Lanes one-cycle start pulses; laneIndividual out Lanes*IndividualWidth per-lane operand; laneFinish in Lanes per-lane done pulses; laneError in Lanes*ErrorWidth per-lane result.
REQ-005 SHALL have ports: resultValid out 1; resultIndex out PopulationAddressWidth; resultError out ErrorWidth; bestIndividual out IndividualWidth; bestError out ErrorWidth; generation out GenerationWidth; busy out 1; done out 1; cycle out 1 generation-complete pulse.

Function
REQ-006 SHALL implement FSM IDLE -> RUN on start; RUN -> DRAIN on stop condition; DRAIN -> DONE when all lanes free and no pending result; DONE -> RUN on start.
REQ-007 On entering RUN, generation, bestError (all ones), bestIndividual (zero) and lane state SHALL clear in the same cycle.
REQ-008 start in RUN or DRAIN SHALL be ignored.
REQ-009 reqReady SHALL be 1 only in RUN with at least one lane free; handshake completes when reqValid and reqReady both 1.
REQ-010 Accepted individual SHALL go to the lowest-numbered free lane; laneIndividual registered and laneStart pulsed high exactly the next cycle; lane marked busy, stores reqIndex.
REQ-011 laneIndividual SHALL hold stable while the lane is busy.
REQ-012 laneFinish on a busy lane SHALL latch laneError and mark lane pending; laneFinish on a free lane SHALL be ignored.
REQ-013 Pending results SHALL be emitted one per cycle, lowest lane first: resultValid=1 with stored index and error; lane becomes free the same cycle.
REQ-014 Simultaneous finishes on k lanes SHALL produce k consecutive result cycles; no result lost.
REQ-015 Lane freed by emission SHALL be reusable for an acceptance in the following cycle, not the same cycle.
REQ-016 On each emitted result, if resultError < bestError, bestError and bestIndividual SHALL update next cycle; ties keep the earlier individual.
REQ-017 A result counter SHALL wrap at 2^PopulationAddressWidth; at wrap generation increments by one and cycle pulses one cycle.
REQ-018 Stop condition: bestError <= threshold, or generation == maxGenerations (maxGenerations=0 stops after first generation completes is NOT allowed; 0 means stop immediately on entering RUN with no acceptance).
REQ-019 In DRAIN, reqReady SHALL be 0; busy lanes complete and emit; best tracking continues.
REQ-020 generation SHALL saturate at all ones, never wrap.
REQ-021 busy SHALL be 1 in RUN and DRAIN; done SHALL be 1 in DONE only, held until start.

Reset
REQ-022 rst low SHALL asynchronously force IDLE, all lanes free, reqReady=0, laneStart=0, resultValid=0, cycle=0, busy=0, done=0, generation=0, bestError all ones, bestIndividual=0, laneIndividual=0.
REQ-023 rst asserted mid-RUN SHALL discard all in-flight lane results; laneFinish arriving after release SHALL be ignored.

Structure
REQ-024 FSM state encoding and default-width constants SHALL live in shared package ga_pkg.
REQ-025 Per-lane busy/pending/index/error storage SHALL be a sub-module morphologic_ga_lane, instantiated Lanes times; arbitration, best tracking and FSM stay in the top.

Verification
REQ-026 Lanes=4, PopulationAddressWidth=2, 4 individuals back-to-back -> lanes 0..3 each get one laneStart, reqReady drops after 4th acceptance.
REQ-027 Lanes 1 and 3 finish same cycle with errors 7 and 2 -> results index(lane1) err 7 then index(lane3) err 2 on consecutive cycles; bestError=2.
REQ-028 threshold=3, a result with error 3 -> DRAIN, reqReady=0, remaining lanes emit, then done=1.
REQ-029 maxGenerations=2, population 4, errors never below threshold -> exactly 8 results, two cycle pulses, generation=2, done=1.
REQ-030 rst low while 3 lanes busy -> all outputs at reset values asynchronously; late laneFinish produces no resultValid.
REQ-031 Equal errors 5 from individuals A then B -> bestIndividual=A.
